mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 8: word count of the shared memory.
REQ-002 Parameter DATA_WIDTH, default 32: data word width.
REQ-003 Parameter DELAY_CYCLES, default 3: memory read latency in cycles, rd_en cycle to rd_data valid; must be >= 1.
REQ-004 Derived: AW = $clog2(MEM_DEPTH); CW = $clog2(DELAY_CYCLES+1).
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  2  per-requester request valid; index i = requester i.
REQ-008 req_ready  output  2  per-requester grant, combinational; transfer = valid & ready.
REQ-009 req_we  input  2  per-requester op select: 1 write, 0 read.
REQ-010 req_addr  input  2xAW  per-requester word address.
REQ-011 req_wdata  input  2xDATA_WIDTH  per-requester write data.
REQ-012 resp_valid  output  2  one-cycle read-response strobe per requester.
REQ-013 resp_data  output  DATA_WIDTH  read data, shared by both requesters; qualified by resp_valid.
REQ-014 req_err  output  2  one-cycle strobe, registered: out-of-range request accepted and dropped.
REQ-015 mem_wr_en, mem_wr_addr (AW), mem_wr_data (DATA_WIDTH)  output  memory write port.
REQ-016 mem_rd_en, mem_rd_addr (AW)  output; mem_rd_data (DATA_WIDTH) input  memory read port.
REQ-017 inflight  output  CW  count of issued reads whose response is not yet delivered.

Function
REQ-018 The block SHALL grant at most one request per cycle; memory write and read are never both enabled in one cycle, so a same-address read/write collision is impossible.
REQ-019 Arbitration SHALL be round-robin:
- single valid requester: granted.
- both valid: grant the requester not granted most recently.
- pointer updates only on a grant.
REQ-020 req_ready SHALL depend on req_valid and the pointer only; req_valid SHALL NOT wait on req_ready.
REQ-021 Granted in-range write: mem_wr_en=1, mem_wr_addr/mem_wr_data = requester's fields, same cycle.
REQ-022 Granted in-range read: mem_rd_en=1, mem_rd_addr = requester's addr, same cycle.
REQ-023 Ungranted cycles: mem_wr_en=0, mem_rd_en=0; address/data outputs driven 0.
REQ-024 Out-of-range (req_addr >= MEM_DEPTH):
- granted normally.
- no memory enable asserted.
- req_err[i] pulses the following cycle.
- reads produce no response.
REQ-025 A DELAY_CYCLES-deep tag shift register of {valid, id} SHALL track reads; the entry for a read granted in cycle t reaches the output stage in cycle t+DELAY_CYCLES.
REQ-026 In cycle t+DELAY_CYCLES:
- resp_valid[id]=1 only.
- resp_data = mem_rd_data, combinationally.
- resp_data = 0 when no response is due.
REQ-027 Reads SHALL be accepted back-to-back, one per cycle, with no stall; responses return in grant order, one per cycle.
REQ-028 inflight SHALL:
- increment on a read issue.
- decrement on a response.
- hold when both occur in the same cycle.
- never exceed DELAY_CYCLES.
REQ-029 Read-after-write to the same address in consecutive cycles SHALL return the new data; no forwarding logic is required.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately clear:
- tag pipeline.
- inflight=0.
- req_err=0.
- resp_valid=0.
- Round-robin pointer set so requester 0 wins the first contention.
REQ-031 req_ready, mem_wr_en and mem_rd_en SHALL be 0 while reset_n=0.
REQ-032 Reset mid-operation SHALL drop all in-flight reads; no resp_valid after release for pre-reset reads.
REQ-033 Memory contents are not cleared by this block.

Verification (MEM_DEPTH=8, DATA_WIDTH=32, DELAY_CYCLES=3)
REQ-034 Req0 write addr 5 data 0xDEADBEEF, next cycle req0 read addr 5 -> resp_valid[0] exactly 3 cycles after read grant, resp_data=0xDEADBEEF.
REQ-035 Both valid every cycle, reads to addrs 1/2 -> grants alternate 0,1,0,1 starting with 0; responses alternate with matching data; inflight saturates at 3.
REQ-036 Req1 issues 4 back-to-back reads addrs 0..3 preloaded 0x10..0x13 -> resp_valid[1] on 4 consecutive cycles, data 0x10..0x13 in order.
REQ-037 MEM_DEPTH=6 variant, req0 read addr 7 -> req_err[0] pulses next cycle, mem_rd_en stays 0, no resp_valid.
REQ-038 Two reads in flight, reset_n pulsed low for 1 cycle -> inflight=0 immediately, no resp_valid in the following 5 cycles.
REQ-039 Read granted while previous write to another address commits -> no X on resp_data; mem_wr_en and mem_rd_en never high in the same cycle (assertion).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the two-port memory arbiter: request handshake, read response and error strobes.
// Index i of every two-entry field belongs to requester i.
interface mem_arbiter_if #(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int AW = $clog2(MEM_DEPTH);

    // A request transfers in any cycle where req_valid[i] & req_ready[i]; requesters raise
    // req_valid without looking at req_ready and hold their fields until the transfer.
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0]                 req_we;
    logic [1:0][AW-1:0]         req_addr;
    logic [1:0][DATA_WIDTH-1:0] req_wdata;
    logic [1:0]                 resp_valid;
    logic [DATA_WIDTH-1:0]      resp_data;
    logic [1:0]                 req_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data, req_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data, req_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters one shared memory port per cycle, with a
// fixed-latency read tag pipeline that routes each read response back to its requester.
module mem_arbiter #(
    parameter int MEM_DEPTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int DELAY_CYCLES = 3,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int CW = $clog2(DELAY_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_arbiter_if.slave          bus,
    output logic                  mem_wr_en,
    output logic [AW-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [CW-1:0]         inflight
);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(MEM_DEPTH);

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    tag_t          tag_q [DELAY_CYCLES];
    logic          last_id;
    logic [1:0]    err_q;
    logic [1:0]    grant;
    logic          gnt_id;
    logic          gnt_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic          in_range;
    logic          wr_issue;
    logic          rd_issue;
    logic          resp_due;

    // The last winner loses a tie; nothing is granted while reset is held.
    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        if (reset_n) begin
            unique case (bus.req_valid)
                2'b01: grant = 2'b01;
                2'b10: begin
                    grant  = 2'b10;
                    gnt_id = 1'b1;
                end
                2'b11: begin
                    if (last_id) begin
                        grant = 2'b01;
                    end else begin
                        grant  = 2'b10;
                        gnt_id = 1'b1;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign gnt_any  = |grant;
    assign sel_we   = bus.req_we[gnt_id];
    assign sel_addr = bus.req_addr[gnt_id];
    assign in_range = {1'b0, sel_addr} < DEPTH_W;
    assign wr_issue = gnt_any & sel_we & in_range;
    assign rd_issue = gnt_any & ~sel_we & in_range;

    assign bus.req_ready = grant;
    assign mem_wr_en     = wr_issue;
    assign mem_wr_addr   = wr_issue ? sel_addr : '0;
    assign mem_wr_data   = wr_issue ? bus.req_wdata[gnt_id] : '0;
    assign mem_rd_en     = rd_issue;
    assign mem_rd_addr   = rd_issue ? sel_addr : '0;

    // The last tag stage lines up with the memory's read data for that read.
    assign resp_due       = tag_q[DELAY_CYCLES-1].valid;
    assign bus.resp_valid = resp_due ? (tag_q[DELAY_CYCLES-1].id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_data  = resp_due ? mem_rd_data : '0;
    assign bus.req_err    = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id  <= 1'b1;
            err_q    <= 2'b00;
            inflight <= '0;
            for (int k = 0; k < DELAY_CYCLES; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (gnt_any) begin
                last_id <= gnt_id;
            end
            err_q    <= (gnt_any && !in_range) ? grant : 2'b00;
            tag_q[0] <= '{valid: rd_issue, id: gnt_id};
            for (int k = 1; k < DELAY_CYCLES; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            unique case ({rd_issue, resp_due})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-based reference model checked every cycle, directed scenarios,
// randomized traffic with occasional resets, and an out-of-range instance with MEM_DEPTH=6.
module tb_mem_arbiter;
    localparam int MEM_DEPTH = 8;
    localparam int DW        = 32;
    localparam int D         = 3;
    localparam int AW        = 3;
    localparam int CW        = 2;
    localparam int QW        = 32 + 1 + DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main instance ----------------
    mem_arbiter_if #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW)) bus ();
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [CW-1:0] inflight;

    mem_arbiter #(.MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW), .DELAY_CYCLES(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .inflight    (inflight)
    );

    // Memory with D cycles of read latency
    logic [DW-1:0] tb_mem  [MEM_DEPTH] = '{default: '0};
    logic [DW-1:0] rd_pipe [D]         = '{default: '0};
    always @(posedge clk) begin
        if (mem_wr_en) tb_mem[mem_wr_addr] <= mem_wr_data;
        rd_pipe[0] <= tb_mem[mem_rd_addr];
        for (int k = 1; k < D; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rd_data = rd_pipe[D-1];

    // ---------------- out-of-range instance ----------------
    mem_arbiter_if #(.MEM_DEPTH(6), .DATA_WIDTH(DW)) bus_b ();
    logic          b_mem_wr_en;
    logic [2:0]    b_mem_wr_addr;
    logic [DW-1:0] b_mem_wr_data;
    logic          b_mem_rd_en;
    logic [2:0]    b_mem_rd_addr;
    logic [DW-1:0] b_mem_rd_data;
    logic [CW-1:0] b_inflight;

    assign b_mem_rd_data = 32'hA5A5_A5A5;

    mem_arbiter #(.MEM_DEPTH(6), .DATA_WIDTH(DW), .DELAY_CYCLES(D)) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_b),
        .mem_wr_en   (b_mem_wr_en),
        .mem_wr_addr (b_mem_wr_addr),
        .mem_wr_data (b_mem_wr_data),
        .mem_rd_en   (b_mem_rd_en),
        .mem_rd_addr (b_mem_rd_addr),
        .mem_rd_data (b_mem_rd_data),
        .inflight    (b_inflight)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [QW-1:0] exp_q[$];
    logic [DW-1:0] shadow [MEM_DEPTH] = '{default: '0};
    int            cyc = 0;
    logic          last_id = 1'b1;
    logic [1:0]    err_pend = 2'b00;

    always @(negedge clk) begin : ref_model
        int            gid;
        logic          gs, gwe, inr, e_wr, e_rd;
        logic [1:0]    eg, erv;
        logic [DW-1:0] erd;
        logic [AW-1:0] ga;
        cyc = cyc + 1;
        check("wr_rd_exclusive", 64'(mem_wr_en & mem_rd_en), 64'd0);
        if (!reset_n) begin
            exp_q.delete();
            last_id  = 1'b1;
            err_pend = 2'b00;
            check("rst_ready", bus.req_ready, 0);
            check("rst_wr_en", mem_wr_en, 0);
            check("rst_rd_en", mem_rd_en, 0);
            check("rst_inflight", inflight, 0);
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_req_err", bus.req_err, 0);
        end else begin
            case (bus.req_valid)
                2'b01:   gid = 0;
                2'b10:   gid = 1;
                2'b11:   gid = last_id ? 0 : 1;
                default: gid = -1;
            endcase
            gs   = (gid == 1);
            eg   = (gid < 0) ? 2'b00 : (gs ? 2'b10 : 2'b01);
            ga   = bus.req_addr[gs];
            gwe  = bus.req_we[gs];
            inr  = int'(ga) < MEM_DEPTH;
            e_wr = (gid >= 0) && gwe && inr;
            e_rd = (gid >= 0) && !gwe && inr;
            check("ready", bus.req_ready, eg);
            check("wr_en", mem_wr_en, e_wr);
            check("wr_addr", mem_wr_addr, e_wr ? ga : '0);
            check("wr_data", mem_wr_data, e_wr ? bus.req_wdata[gs] : '0);
            check("rd_en", mem_rd_en, e_rd);
            check("rd_addr", mem_rd_addr, e_rd ? ga : '0);
            check("req_err", bus.req_err, err_pend);
            check("inflight", inflight, exp_q.size());
            erv = 2'b00;
            erd = '0;
            if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) == cyc) begin
                erv = exp_q[0][DW] ? 2'b10 : 2'b01;
                erd = exp_q[0][DW-1:0];
                void'(exp_q.pop_front());
            end
            check("resp_valid", bus.resp_valid, erv);
            check("resp_data", bus.resp_data, erd);
            check("resp_data_known", 64'($isunknown(bus.resp_data)), 64'd0);
            if (gid >= 0) last_id = gs;
            err_pend = ((gid >= 0) && !inr) ? eg : 2'b00;
            if (e_wr) shadow[ga] = bus.req_wdata[gs];
            if (e_rd) exp_q.push_back({32'(cyc + D), gs, shadow[ga]});
        end
    end

    // ---------------- driver tasks ----------------
    logic [1:0]    s_ready, s_rv, s_err;
    logic [DW-1:0] s_rd;
    logic [CW-1:0] s_inf;

    task automatic tick();
        @(negedge clk);
        s_ready = bus.req_ready;
        s_rv    = bus.resp_valid;
        s_rd    = bus.resp_data;
        s_err   = bus.req_err;
        s_inf   = inflight;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_addr[0]  = a0;
        bus.req_addr[1]  = a1;
        bus.req_wdata[0] = d0;
        bus.req_wdata[1] = d1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    logic [1:0]    sb_ready, sb_rv, sb_err;
    logic [DW-1:0] sb_rd;
    logic          sb_wr, sb_rden;
    logic [CW-1:0] sb_inf;

    task automatic step_b(input logic [1:0] v, input logic [1:0] we, input logic [2:0] a0,
                          input logic [2:0] a1);
        bus_b.req_valid    = v;
        bus_b.req_we       = we;
        bus_b.req_addr[0]  = a0;
        bus_b.req_addr[1]  = a1;
        bus_b.req_wdata[0] = 32'h0BAD_0BAD;
        bus_b.req_wdata[1] = 32'h0BAD_0BAD;
        @(negedge clk);
        sb_ready = bus_b.req_ready;
        sb_rv    = bus_b.resp_valid;
        sb_rd    = bus_b.resp_data;
        sb_err   = bus_b.req_err;
        sb_wr    = b_mem_wr_en;
        sb_rden  = b_mem_rd_en;
        sb_inf   = b_inflight;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [1:0]    cur_v, cur_we, acc;
    logic [AW-1:0] cur_a [2];
    logic [DW-1:0] cur_d [2];

    initial begin
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // write then read-after-write, response exactly D cycles after the read grant
        step(2'b01, 2'b01, 3'd5, 3'd0, 32'hDEAD_BEEF, '0);
        check("raw_wr_grant", s_ready, 2'b01);
        step(2'b01, 2'b00, 3'd5, 3'd0, '0, '0);
        check("raw_rd_grant", s_ready, 2'b01);
        step(2'b00, 2'b00, '0, '0, '0, '0);
        check("raw_early1", s_rv, 2'b00);
        step(2'b00, 2'b00, '0, '0, '0, '0);
        check("raw_early2", s_rv, 2'b00);
        step(2'b00, 2'b00, '0, '0, '0, '0);
        check("raw_resp_valid", s_rv, 2'b01);
        check("raw_resp_data", s_rd, 32'hDEAD_BEEF);

        // contention: alternate grants starting with requester 0, inflight saturates
        step(2'b01, 2'b01, 3'd1, 3'd0, 32'h1111_0001, '0);
        step(2'b10, 2'b10, 3'd0, 3'd2, '0, 32'h2222_0002);
        idle(3);
        for (int k = 0; k < 8; k++) begin
            step(2'b11, 2'b00, 3'd1, 3'd2, '0, '0);
            check("rr_grant", s_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k >= 3) begin
                check("rr_resp_valid", s_rv, ((k - 3) % 2 == 0) ? 2'b01 : 2'b10);
                check("rr_resp_data", s_rd, ((k - 3) % 2 == 0) ? 32'h1111_0001 : 32'h2222_0002);
                check("rr_inflight", s_inf, 2'd3);
            end
        end
        idle(4);

        // back-to-back reads by requester 1
        for (int i = 0; i < 4; i++) step(2'b10, 2'b10, '0, AW'(i), '0, DW'(32'h10 + i));
        for (int s = 0; s < 8; s++) begin
            if (s < 4) step(2'b10, 2'b00, '0, AW'(s), '0, '0);
            else idle(1);
            if (s >= 3 && s <= 6) begin
                check("b2b_resp_valid", s_rv, 2'b10);
                check("b2b_resp_data", s_rd, DW'(32'h10 + s - 3));
            end
        end

        // write commits while another requester's read follows
        step(2'b11, 2'b01, 3'd3, 3'd4, 32'hCAFE_F00D, '0);
        check("wr_then_rd_g0", s_ready, 2'b01);
        step(2'b10, 2'b00, 3'd0, 3'd4, '0, '0);
        check("wr_then_rd_g1", s_ready, 2'b10);
        idle(3);
        check("wr_then_rd_data", s_rd, 32'h0);
        step(2'b10, 2'b00, 3'd0, 3'd3, '0, '0);
        idle(3);
        check("wr_commit_data", s_rd, 32'hCAFE_F00D);

        // reset with two reads in flight
        step(2'b01, 2'b00, 3'd1, 3'd0, '0, '0);
        step(2'b10, 2'b00, 3'd0, 3'd2, '0, '0);
        reset_n = 1'b0;
        bus.req_valid = 2'b11;
        tick();
        check("mid_rst_inflight", s_inf, 0);
        check("mid_rst_ready", s_ready, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("post_rst_no_resp", s_rv, 2'b00);
        end

        // out-of-range accesses on the MEM_DEPTH=6 instance
        step_b(2'b01, 2'b00, 3'd7, 3'd0);
        check("oor_rd_grant", sb_ready, 2'b01);
        check("oor_rd_en", sb_rden, 1'b0);
        check("oor_err_late", sb_err, 2'b00);
        step_b(2'b00, 2'b00, 3'd0, 3'd0);
        check("oor_err_pulse", sb_err, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step_b(2'b00, 2'b00, 3'd0, 3'd0);
            check("oor_no_resp", sb_rv, 2'b00);
            check("oor_err_once", sb_err, 2'b00);
            check("oor_inflight", sb_inf, 0);
        end
        step_b(2'b10, 2'b10, 3'd0, 3'd6);
        check("oor_wr_grant", sb_ready, 2'b10);
        check("oor_wr_en", sb_wr, 1'b0);
        step_b(2'b00, 2'b00, 3'd0, 3'd0);
        check("oor_wr_err", sb_err, 2'b10);
        step_b(2'b01, 2'b00, 3'd5, 3'd0);
        check("inr_rd_en", sb_rden, 1'b1);
        step_b(2'b00, 2'b00, 3'd0, 3'd0);
        step_b(2'b00, 2'b00, 3'd0, 3'd0);
        step_b(2'b00, 2'b00, 3'd0, 3'd0);
        check("inr_resp_valid", sb_rv, 2'b01);
        check("inr_resp_data", sb_rd, 32'hA5A5_A5A5);

        // randomized traffic; requests are held until accepted
        cur_v = '0; cur_we = '0; acc = '0;
        cur_a[0] = '0; cur_a[1] = '0; cur_d[0] = '0; cur_d[1] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!cur_v[i] || acc[i]) begin
                    cur_v[i]  = ($urandom_range(0, 3) != 0);
                    cur_we[i] = ($urandom_range(0, 2) == 0);
                    cur_a[i]  = AW'($urandom_range(0, MEM_DEPTH - 1));
                    cur_d[i]  = $urandom;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                reset_n = 1'b1;
                acc = '0;
            end else begin
                step(cur_v, cur_we, cur_a[0], cur_a[1], cur_d[0], cur_d[1]);
                acc = cur_v & s_ready;
            end
        end
        idle(D + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
